// File: rtl/flit_rr_mux_if.sv
// Flit port bundle between the input ports and the round-robin mux plus its output link.
// The master modport is the side that drives flits in and accepts the output; the mux uses slave.
interface flit_rr_mux_if #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned DATAW = 64,
  parameter int unsigned VCHW  = 2
);
  localparam int unsigned FLITW = DATAW + 2;

  logic [NPORT*FLITW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready;
  logic [FLITW-1:0]       odata;
  logic                   ovalid;
  logic [VCHW-1:0]        ovch;
  logic                   oready;
  logic [NPORT-1:0]       ogrant;
  logic                   oerr;

  modport master (
    output idata, ivalid, ivch, oready,
    input  iready, odata, ovalid, ovch, ogrant, oerr
  );

  modport slave (
    input  idata, ivalid, ivch, oready,
    output iready, odata, ovalid, ovch, ogrant, oerr
  );
endinterface

// File: rtl/flit_rr_mux.sv
// Registered N-to-1 flit mux: round-robin grant per packet (HEAD..TAIL), one output register stage.
// Non-HEAD flits arriving while idle are consumed and dropped with a one-cycle oerr pulse.
module flit_rr_mux #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned DATAW = 64,
  parameter int unsigned VCHW  = 2
) (
  input  logic         clk,
  input  logic         rst_,
  flit_rr_mux_if.slave bus
);
  localparam int unsigned FLITW = DATAW + 2;
  localparam int unsigned PW    = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned IW    = PW + 1;
  localparam logic [1:0]  T_HEAD = 2'b01;
  localparam logic [1:0]  T_TAIL = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [FLITW-1:0]   data_q, data_d;
  logic [VCHW-1:0]    vch_q, vch_d;
  logic               valid_q, valid_d;
  logic [NPORT-1:0]   grant_q, grant_d;
  logic               err_q, err_d;

  logic               load;
  logic               found;
  logic               accept;
  logic [PW-1:0]      pick;
  logic [PW-1:0]      sel;
  logic [IW-1:0]      idx;
  logic [FLITW-1:0]   sel_flit;
  logic [VCHW-1:0]    sel_vch;
  logic [1:0]         sel_type;
  logic [NPORT-1:0]   iready;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (p == PW'(NPORT - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register: reset drops any held flit and in-flight packet
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      vch_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      vch_q   <= vch_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // Arbitration and handshake: round-robin pick in IDLE, owner only while LOCKED
  always_comb begin
    load     = !valid_q || bus.oready;
    pick     = rr_q;
    found    = 1'b0;
    idx      = '0;
    sel_flit = '0;
    sel_vch  = '0;
    iready   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      idx = IW'(rr_q) + IW'(i);
      if (idx >= IW'(NPORT)) idx = idx - IW'(NPORT);
      if (!found && bus.ivalid[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
    sel = (state_q == LOCKED) ? owner_q : pick;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (sel == PW'(p)) begin
        sel_flit = bus.idata[p*FLITW +: FLITW];
        sel_vch  = bus.ivch[p*VCHW +: VCHW];
      end
    end
    sel_type = sel_flit[FLITW-1 -: 2];
    if (rst_ && ((state_q == LOCKED) || found)) iready[sel] = load;
    accept = iready[sel] && bus.ivalid[sel];
  end

  // Next state and output-register update
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    data_d  = data_q;
    vch_d   = vch_q;
    valid_d = valid_q;
    grant_d = grant_q;
    err_d   = 1'b0;
    if (load) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_type == T_HEAD) begin
            state_d = LOCKED;
            owner_d = pick;
            grant_d = NPORT'(1) << pick;
            data_d  = sel_flit;
            vch_d   = sel_vch;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
            rr_d  = next_port(pick);
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          data_d  = sel_flit;
          vch_d   = sel_vch;
          valid_d = 1'b1;
          if (sel_type == T_TAIL) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = next_port(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.iready = iready;
  assign bus.odata  = data_q;
  assign bus.ovalid = valid_q;
  assign bus.ovch   = vch_q;
  assign bus.ogrant = grant_q;
  assign bus.oerr   = err_q;
endmodule
